// File: rtl/avmm_emif16_master.sv
// -----------------------------------------------------------------------------
// avmm_emif16_master
//
// Avalon-MM slave front end that drives an EMIF16 asynchronous target. Each
// Avalon read or write becomes one EMIF16 cycle built from programmable
// setup / strobe / hold phases. When the target requests extended wait, the
// strobe is stretched until wait clears or a timeout expires. A turnaround
// phase then releases the bus.
//
// Ports
//   clk_i, rst_n_i          single clock, asynchronous active-low reset
//   avs_address_i           EMIF16 word address
//   avs_byteenable_i        byte enables, active-high
//   avs_read_i/write_i      request strobes (read wins if both are high)
//   avs_writedata_i         write data
//   avs_readdata_o          read data, held from one read capture to the next
//   avs_waitrequest_o       low for exactly one cycle: the last HOLD cycle
//   timeout_o               one-cycle pulse when extended wait is aborted
//   e_addr_o, e_ben_o       EMIF16 address and active-low byte enables
//   e_cen_o, e_wen_o, e_oen_o  chip enable, write strobe, output enable (low)
//   e_wait_i                asynchronous target wait, polarity WAIT_POL
//   e_data_i/e_data_o       data bus in / out
//   e_data_oe_o             data bus output enable, active-high
// -----------------------------------------------------------------------------
module avmm_emif16_master #(
  parameter int unsigned W_SETUP      = 2,
  parameter int unsigned W_STROBE     = 4,
  parameter int unsigned W_HOLD       = 2,
  parameter int unsigned R_SETUP      = 2,
  parameter int unsigned R_STROBE     = 4,
  parameter int unsigned R_HOLD       = 2,
  parameter int unsigned TA           = 2,
  parameter bit          EW           = 1'b1,
  parameter bit          WAIT_POL     = 1'b1,
  parameter int unsigned WAIT_TIMEOUT = 1023
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [23:0] avs_address_i,
  input  logic [1:0]  avs_byteenable_i,
  input  logic        avs_read_i,
  input  logic        avs_write_i,
  input  logic [15:0] avs_writedata_i,
  output logic [15:0] avs_readdata_o,
  output logic        avs_waitrequest_o,
  output logic        timeout_o,
  output logic [23:0] e_addr_o,
  output logic [1:0]  e_ben_o,
  output logic        e_cen_o,
  output logic        e_wen_o,
  output logic        e_oen_o,
  input  logic        e_wait_i,
  input  logic [15:0] e_data_i,
  output logic [15:0] e_data_o,
  output logic        e_data_oe_o
);

  // One shared counter serves every phase; it must hold the largest strobe
  // length (63) and the largest extended-wait count.
  localparam int unsigned CNT_MAX = (WAIT_TIMEOUT > 63) ? WAIT_TIMEOUT : 63;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    IDLE, SETUP, STROBE, EXTWAIT, HOLD, TURN
  } state_t;

  state_t           state;
  logic             is_rd;
  logic [CNT_W-1:0] cnt;

  logic             wait_meta;
  logic             wait_sync;
  logic             wait_act;

  logic             accept;
  logic             strobe_done;
  logic             strobe_abort;
  logic [CNT_W-1:0] strobe_m1;
  logic [CNT_W-1:0] hold_m1;

  // Two-flop synchronizer for the asynchronous target wait. The flops reset
  // to the "ready" level so a freshly reset link never starts in wait.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      // NOTE: clocked state is always assigned with <= so every flop samples
      // the pre-edge value of every other flop, independent of block order.
      wait_meta <= ~WAIT_POL;
      wait_sync <= ~WAIT_POL;
    end else begin
      wait_meta <= e_wait_i;
      wait_sync <= wait_meta;
    end
  end

  assign wait_act = (wait_sync == WAIT_POL);

  // A new request is taken in IDLE or in the last TURN cycle, so that
  // back-to-back accesses are separated by exactly TA cycles of CEn high.
  assign accept = ((state == IDLE) || ((state == TURN) && (cnt == '0))) &&
                  (avs_read_i || avs_write_i);

  always_comb begin
    // NOTE: every always_comb output gets a default first so that no path
    // leaves it unassigned, which would otherwise infer a latch.
    strobe_m1    = is_rd ? CNT_W'(R_STROBE - 1) : CNT_W'(W_STROBE - 1);
    hold_m1      = is_rd ? CNT_W'(R_HOLD - 1)   : CNT_W'(W_HOLD - 1);
    strobe_done  = 1'b0;
    strobe_abort = 1'b0;
    if ((state == STROBE) && (cnt == '0) && !(EW && wait_act)) begin
      strobe_done = 1'b1;
    end
    if (state == EXTWAIT) begin
      if (!wait_act) begin
        strobe_done = 1'b1;
      end else if (cnt == CNT_W'(WAIT_TIMEOUT)) begin
        strobe_abort = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state             <= IDLE;
      is_rd             <= 1'b0;
      cnt               <= '0;
      avs_readdata_o    <= '0;
      avs_waitrequest_o <= 1'b1;
      timeout_o         <= 1'b0;
      e_addr_o          <= '0;
      e_ben_o           <= 2'b11;
      e_cen_o           <= 1'b1;
      e_wen_o           <= 1'b1;
      e_oen_o           <= 1'b1;
      e_data_o          <= '0;
      e_data_oe_o       <= 1'b0;
    end else begin
      // Pulsed outputs default to their idle level every cycle.
      avs_waitrequest_o <= 1'b1;
      timeout_o         <= 1'b0;

      unique case (state)
        IDLE: ;

        SETUP: begin
          if (cnt == '0) begin
            state <= STROBE;
            cnt   <= strobe_m1;
            if (is_rd) e_oen_o <= 1'b0;
            else       e_wen_o <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        STROBE: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else if (EW && wait_act) begin
            // Strobe stays low; cnt now counts extended-wait cycles from 1.
            state <= EXTWAIT;
            cnt   <= CNT_W'(1);
          end
        end

        EXTWAIT: begin
          if (wait_act && (cnt != CNT_W'(WAIT_TIMEOUT))) begin
            cnt <= cnt + 1'b1;
          end
        end

        HOLD: begin
          if (cnt == '0) begin
            state       <= TURN;
            cnt         <= CNT_W'(TA - 1);
            e_cen_o     <= 1'b1;
            e_ben_o     <= 2'b11;
            e_data_oe_o <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
            if (cnt == CNT_W'(1)) avs_waitrequest_o <= 1'b0;
          end
        end

        TURN: begin
          if (cnt == '0) state <= IDLE;
          else           cnt   <= cnt - 1'b1;
        end

        default: state <= IDLE;
      endcase

      // End of the strobe-low span, normal or aborted. Read data is captured
      // on this same edge; an aborted read returns zero.
      if (strobe_done || strobe_abort) begin
        state   <= HOLD;
        cnt     <= hold_m1;
        e_wen_o <= 1'b1;
        e_oen_o <= 1'b1;
        if (is_rd) avs_readdata_o <= strobe_abort ? 16'h0000 : e_data_i;
        if (strobe_abort) timeout_o <= 1'b1;
        if (hold_m1 == '0) avs_waitrequest_o <= 1'b0;
      end

      // Request capture. Written last so it takes precedence over the TURN
      // branch above when the last turnaround cycle accepts a new access.
      if (accept) begin
        state       <= SETUP;
        is_rd       <= avs_read_i;
        cnt         <= avs_read_i ? CNT_W'(R_SETUP - 1) : CNT_W'(W_SETUP - 1);
        e_addr_o    <= avs_address_i;
        e_ben_o     <= ~avs_byteenable_i;
        e_data_o    <= avs_writedata_i;
        e_data_oe_o <= ~avs_read_i;
        e_cen_o     <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_avmm_emif16_master.sv
// -----------------------------------------------------------------------------
// tb_avmm_emif16_master
//
// Directed and randomized accesses against a behavioural EMIF16 target. The
// expected timing of each access comes from the phase lengths and from the
// wait waveform seen through a two-cycle synchronizer; expected read data
// comes from a reference memory updated with Avalon byte-enable rules.
// -----------------------------------------------------------------------------
module tb_avmm_emif16_master;

  localparam int unsigned W_SETUP      = 1;
  localparam int unsigned W_STROBE     = 2;
  localparam int unsigned W_HOLD       = 1;
  localparam int unsigned R_SETUP      = 2;
  localparam int unsigned R_STROBE     = 3;
  localparam int unsigned R_HOLD       = 2;
  localparam int unsigned TA           = 2;
  localparam bit          EW           = 1'b1;
  localparam bit          WAIT_POL     = 1'b1;
  localparam int unsigned WAIT_TIMEOUT = 16;
  localparam int          NO_WAIT      = 0;

  logic        clk_i;
  logic        rst_n_i;
  logic [23:0] avs_address_i;
  logic [1:0]  avs_byteenable_i;
  logic        avs_read_i;
  logic        avs_write_i;
  logic [15:0] avs_writedata_i;
  logic [15:0] avs_readdata_o;
  logic        avs_waitrequest_o;
  logic        timeout_o;
  logic [23:0] e_addr_o;
  logic [1:0]  e_ben_o;
  logic        e_cen_o;
  logic        e_wen_o;
  logic        e_oen_o;
  logic        e_wait_i;
  logic [15:0] e_data_i;
  logic [15:0] e_data_o;
  logic        e_data_oe_o;

  int n_vec = 0;
  int n_err = 0;

  // Target memory (written from the EMIF bus) and reference memory (written
  // by the bench from the Avalon side).
  logic [15:0] tmem    [256] = '{default: 16'h0000};
  logic [15:0] ref_mem [256] = '{default: 16'h0000};

  avmm_emif16_master #(
    .W_SETUP(W_SETUP), .W_STROBE(W_STROBE), .W_HOLD(W_HOLD),
    .R_SETUP(R_SETUP), .R_STROBE(R_STROBE), .R_HOLD(R_HOLD),
    .TA(TA), .EW(EW), .WAIT_POL(WAIT_POL), .WAIT_TIMEOUT(WAIT_TIMEOUT)
  ) dut (
    .clk_i(clk_i),
    .rst_n_i(rst_n_i),
    .avs_address_i(avs_address_i),
    .avs_byteenable_i(avs_byteenable_i),
    .avs_read_i(avs_read_i),
    .avs_write_i(avs_write_i),
    .avs_writedata_i(avs_writedata_i),
    .avs_readdata_o(avs_readdata_o),
    .avs_waitrequest_o(avs_waitrequest_o),
    .timeout_o(timeout_o),
    .e_addr_o(e_addr_o),
    .e_ben_o(e_ben_o),
    .e_cen_o(e_cen_o),
    .e_wen_o(e_wen_o),
    .e_oen_o(e_oen_o),
    .e_wait_i(e_wait_i),
    .e_data_i(e_data_i),
    .e_data_o(e_data_o),
    .e_data_oe_o(e_data_oe_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Behavioural target: reads are combinational, writes land on the rising
  // edge of the write strobe while chip enable is still low.
  assign e_data_i = tmem[e_addr_o[7:0]];

  always @(posedge e_wen_o) begin
    if (rst_n_i && !e_cen_o) begin
      if (!e_ben_o[0]) tmem[e_addr_o[7:0]][7:0]  = e_data_o[7:0];
      if (!e_ben_o[1]) tmem[e_addr_o[7:0]][15:8] = e_data_o[15:8];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // The master sees the wait pin two cycles late through its synchronizer.
  function automatic bit seen(input int n, input int wf, input int wt);
    return (n - 2 >= wf) && (n - 2 < wt);
  endfunction

  // One Avalon access. The target drives wait during cycles [wf, wt), where
  // both are given relative to the last nominal strobe cycle s. Cycle 0 is
  // the cycle in which the request is first presented.
  task automatic access(input string tag, input bit rd, input logic [23:0] addr,
                        input logic [1:0] be, input logic [15:0] wd,
                        input int wf_rel, input int wt_rel);
    int setup_n  = rd ? int'(R_SETUP)  : int'(W_SETUP);
    int strobe_n = rd ? int'(R_STROBE) : int'(W_STROBE);
    int hold_n   = rd ? int'(R_HOLD)   : int'(W_HOLD);
    int s        = setup_n + strobe_n;
    int wf       = s + wf_rel;
    int wt       = s + wt_rel;
    int ext      = 0;
    bit exp_to   = 1'b0;
    int exp_len;
    logic [15:0] exp_rd;
    int cen_n = 0, stb_n = 0, to_n = 0, bad_bus = 0, wreq_cyc = -1;
    logic [15:0] rdata = 16'h0000;

    // Expected strobe extension: wait seen on the last strobe cycle stretches
    // the strobe until the first cycle wait is no longer seen, capped at the
    // timeout (which then aborts the access).
    if (EW && seen(s, wf, wt)) begin
      ext    = int'(WAIT_TIMEOUT);
      exp_to = 1'b1;
      for (int e = 1; e <= int'(WAIT_TIMEOUT); e++) begin
        if (!seen(s + e, wf, wt)) begin
          ext    = e;
          exp_to = 1'b0;
          break;
        end
      end
    end
    exp_len = setup_n + strobe_n + ext + hold_n;
    exp_rd  = exp_to ? 16'h0000 : ref_mem[addr[7:0]];

    @(posedge clk_i); #1;
    avs_address_i    = addr;
    avs_byteenable_i = be;
    avs_writedata_i  = wd;
    avs_read_i       = rd;
    avs_write_i      = !rd;
    for (int c = 0; c < 200; c++) begin
      e_wait_i = (c >= wf && c < wt) ? WAIT_POL : !WAIT_POL;
      @(negedge clk_i);
      if (!e_cen_o) begin
        cen_n++;
        if (e_addr_o !== addr || e_ben_o !== ~be || e_data_oe_o !== !rd) bad_bus++;
        if (!rd && e_data_o !== wd) bad_bus++;
      end
      if (rd ? !e_oen_o : !e_wen_o) stb_n++;
      if (rd ? !e_wen_o : !e_oen_o) bad_bus++;
      if (timeout_o) to_n++;
      if (!avs_waitrequest_o) begin
        wreq_cyc = c;
        rdata    = avs_readdata_o;
        break;
      end
      @(posedge clk_i); #1;
    end
    @(posedge clk_i); #1;
    avs_read_i  = 1'b0;
    avs_write_i = 1'b0;
    e_wait_i    = !WAIT_POL;
    repeat (TA + 2) begin
      @(negedge clk_i);
      if (!e_cen_o) cen_n++;
      if (timeout_o) to_n++;
      @(posedge clk_i); #1;
    end

    check({tag, ".wreq_cycle"}, wreq_cyc, exp_len);
    check({tag, ".cen_cycles"}, cen_n, exp_len);
    check({tag, ".strobe_cycles"}, stb_n, strobe_n + ext);
    check({tag, ".bus_errors"}, bad_bus, 0);
    check({tag, ".timeout_pulses"}, to_n, int'(exp_to));
    if (rd) begin
      check({tag, ".readdata"}, rdata, exp_rd);
    end else begin
      if (be[0]) ref_mem[addr[7:0]][7:0]  = wd[7:0];
      if (be[1]) ref_mem[addr[7:0]][15:8] = wd[15:8];
    end
  endtask

  initial begin
    rst_n_i          = 1'b0;
    avs_address_i    = '0;
    avs_byteenable_i = '0;
    avs_read_i       = 1'b0;
    avs_write_i      = 1'b0;
    avs_writedata_i  = '0;
    e_wait_i         = !WAIT_POL;

    // Reset state.
    repeat (2) @(posedge clk_i);
    #1;
    check("rst.waitrequest", avs_waitrequest_o, 1);
    check("rst.readdata", avs_readdata_o, 0);
    check("rst.timeout", timeout_o, 0);
    check("rst.strobes", {e_cen_o, e_wen_o, e_oen_o}, 3'b111);
    check("rst.ben", e_ben_o, 2'b11);
    check("rst.addr", e_addr_o, 0);
    check("rst.data", {e_data_oe_o, e_data_o}, 0);
    rst_n_i = 1'b1;
    repeat (2) @(posedge clk_i);

    // Basic write, readback, partial-byte write and readback.
    access("wr_full", 1'b0, 24'h001234, 2'b11, 16'hA55A, NO_WAIT, NO_WAIT);
    access("rd_full", 1'b1, 24'h001234, 2'b11, 16'h0000, NO_WAIT, NO_WAIT);
    access("wr_byte", 1'b0, 24'h001234, 2'b01, 16'h00C3, NO_WAIT, NO_WAIT);
    access("rd_byte", 1'b1, 24'h001234, 2'b11, 16'h0000, NO_WAIT, NO_WAIT);

    // Extended wait: asserted 2 cycles before strobe end, released so the
    // strobe is stretched by 5 cycles.
    access("rd_extwait", 1'b1, 24'h001234, 2'b11, 16'h0000, -2, 3);

    // Stuck wait: timeout aborts a read of a nonzero location, then a normal
    // read follows.
    access("wr_to_loc", 1'b0, 24'h000040, 2'b11, 16'hBEEF, NO_WAIT, NO_WAIT);
    access("rd_timeout", 1'b1, 24'h000040, 2'b11, 16'h0000, -5, 1000);
    access("rd_after_to", 1'b1, 24'h000040, 2'b11, 16'h0000, NO_WAIT, NO_WAIT);

    // Reset asserted in the middle of a write strobe.
    @(posedge clk_i); #1;
    avs_address_i    = 24'h000077;
    avs_byteenable_i = 2'b11;
    avs_writedata_i  = 16'h1111;
    avs_write_i      = 1'b1;
    for (int k = 0; k < 20; k++) begin
      if (!e_wen_o) break;
      @(posedge clk_i); #1;
    end
    check("abort.in_strobe", e_wen_o, 0);
    rst_n_i = 1'b0;
    #1;
    check("abort.strobes", {e_cen_o, e_wen_o, e_oen_o}, 3'b111);
    check("abort.data_oe", e_data_oe_o, 0);
    check("abort.waitrequest", avs_waitrequest_o, 1);
    check("abort.readdata", avs_readdata_o, 0);
    check("abort.ben", e_ben_o, 2'b11);
    avs_write_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    rst_n_i = 1'b1;
    repeat (3) @(posedge clk_i);
    access("rd_aborted", 1'b1, 24'h000077, 2'b11, 16'h0000, NO_WAIT, NO_WAIT);
    access("wr_post_rst", 1'b0, 24'h000077, 2'b11, 16'h2222, NO_WAIT, NO_WAIT);
    access("rd_post_rst", 1'b1, 24'h000077, 2'b11, 16'h0000, NO_WAIT, NO_WAIT);

    // Randomized accesses over a small address window, some with wait.
    for (int i = 0; i < 12; i++) begin
      bit          rd    = 1'($urandom_range(0, 1));
      logic [23:0] addr  = 24'h000100 + 24'($urandom_range(0, 3));
      logic [1:0]  be    = 2'($urandom_range(0, 3));
      logic [15:0] wd    = 16'($urandom);
      int          wf_r  = NO_WAIT;
      int          wt_r  = NO_WAIT;
      if ($urandom_range(0, 1) == 1) begin
        wf_r = -2 - int'($urandom_range(0, 1));
        wt_r = int'($urandom_range(0, 4));
      end
      access($sformatf("rnd%0d", i), rd, addr, be, wd, wf_r, wt_r);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
